wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 29 ++
 rtl/wb_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: ALU and memory result inputs, register-file write port and status.
interface wb_arbiter_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic [31:0]   alu_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [4:0]    mem_rd;
  logic [31:0]   mem_data;
  logic          rf_we;
  logic [4:0]    rf_a3;
  logic [31:0]   rf_wd3;
  logic [CW-1:0] fifo_count;
  logic          idle;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  mem_ready, rf_we, rf_a3, rf_wd3, fifo_count, idle
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output mem_ready, rf_we, rf_a3, rf_wd3, fifo_count, idle
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU results win, load results queue in a FIFO and drain when the ALU is quiet.
// Optional macro WB_BYPASS_EN: a load result skips the empty FIFO when no ALU write competes.
module wb_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input logic         clk,
  input logic         reset,
  wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t        buf_q [FIFO_DEPTH];
  entry_t        buf_d [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_a3_q, rf_a3_d;
  logic [31:0]   rf_wd3_q, rf_wd3_d;

  logic empty;
  logic full;
  logic alu_sel;
  logic mem_acc;
  logic bypass;
  logic push;
  logic pop;

  // Source selection, FIFO bookkeeping and next write-port values.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CW'(FIFO_DEPTH));
    alu_sel = bus.alu_valid && (bus.alu_rd != 5'd0);
    // Readiness comes from occupancy alone, so a full buffer refuses even when its head pops.
    mem_acc = bus.mem_valid && !full && (bus.mem_rd != 5'd0);
`ifdef WB_BYPASS_EN
    bypass  = mem_acc && empty && !alu_sel;
`else
    bypass  = 1'b0;
`endif
    pop     = !alu_sel && !empty;
    push    = mem_acc && !bypass;

    buf_d    = buf_q;
    rf_we_d  = 1'b0;
    rf_a3_d  = rf_a3_q;
    rf_wd3_d = rf_wd3_q;

    if (alu_sel) begin
      rf_we_d  = 1'b1;
      rf_a3_d  = bus.alu_rd;
      rf_wd3_d = bus.alu_data;
    end else if (pop) begin
      rf_we_d  = 1'b1;
      rf_a3_d  = buf_q[rd_ptr_q].rd;
      rf_wd3_d = buf_q[rd_ptr_q].data;
    end else if (bypass) begin
      rf_we_d  = 1'b1;
      rf_a3_d  = bus.mem_rd;
      rf_wd3_d = bus.mem_data;
    end else begin
      rf_we_d  = 1'b0;
    end

    // The tail never aliases the head while a pop is possible, since a full buffer never pushes.
    if (push) begin
      buf_d[wr_ptr_q] = '{rd: bus.mem_rd, data: bus.mem_data};
      wr_ptr_d        = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // State update with synchronous reset clearing the buffer and write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      rf_we_q  <= 1'b0;
      rf_a3_q  <= 5'd0;
      rf_wd3_q <= 32'd0;
    end else begin
      buf_q    <= buf_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rf_we_q  <= rf_we_d;
      rf_a3_q  <= rf_a3_d;
      rf_wd3_q <= rf_wd3_d;
    end
  end

  assign bus.mem_ready  = !full;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_a3      = rf_a3_q;
  assign bus.rf_wd3     = rf_wd3_q;
  assign bus.fifo_count = count_q;
  assign bus.idle       = empty && !rf_we_q;
endmodule
